// File: rtl/ppfifo_sc.sv
// ============================================================================
// Module      : ppfifo_sc
// Description : Single-clock ping-pong FIFO with two equal buffers. Whole
//               blocks are written through the rdy/act/size/stb handshake
//               and drained in commit order through the mirror-image read
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppfifo_sc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [1:0]            o_wr_rdy,
  input  logic [1:0]            i_wr_act,
  output logic [15:0]           o_wr_size,
  input  logic                  i_wr_stb,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_rdy,
  input  logic                  i_rd_act,
  output logic [15:0]           o_rd_size,
  input  logic                  i_rd_stb,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_FULL    = 2'd2,
    BUF_READING = 2'd3
  } buf_state_t;

  buf_state_t            buf_state [2];
  logic [ADDR_WIDTH:0]   buf_size  [2];
  logic [DATA_WIDTH-1:0] mem       [2*DEPTH];

  logic                  wr_sel;
  logic                  rd_sel;
  logic [ADDR_WIDTH:0]   wr_cnt;
  logic [ADDR_WIDTH:0]   rd_addr;
  logic                  wr_en;
  logic                  rd_en;

  // A word is accepted only while the claim is still held and the buffer has room;
  // a strobe coinciding with the act fall belongs to no block and is dropped.
  assign wr_en = (buf_state[wr_sel] == BUF_WRITING) && i_wr_act[wr_sel] &&
                 i_wr_stb && (wr_cnt < DEPTH_CNT);

  // Read strobes past the committed size are ignored, as are strobes on the release cycle.
  assign rd_en = (buf_state[rd_sel] == BUF_READING) && i_rd_act &&
                 i_rd_stb && (rd_addr < buf_size[rd_sel]);

  assign o_wr_size = 16'(DEPTH);
  assign o_rd_size = ((buf_state[rd_sel] == BUF_FULL) || (buf_state[rd_sel] == BUF_READING))
                     ? 16'(buf_size[rd_sel]) : 16'd0;

  // Buffer storage; deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_sel, wr_cnt[ADDR_WIDTH-1:0]}] <= i_wr_data;
    end
  end

  // Per-buffer state machines plus the write and read pointers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_state[0] <= BUF_EMPTY;
      buf_state[1] <= BUF_EMPTY;
      buf_size[0]  <= '0;
      buf_size[1]  <= '0;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      wr_cnt       <= '0;
      rd_addr      <= '0;
      o_wr_rdy     <= 2'b00;
      o_rd_rdy     <= 1'b0;
      o_rd_data    <= '0;
      o_rd_valid   <= 1'b0;
    end else begin
      // Readiness reflects the state before this edge, so a freed buffer
      // advertises itself one edge after it becomes empty.
      if ((buf_state[wr_sel] == BUF_EMPTY) && (i_wr_act == 2'b00)) begin
        o_wr_rdy <= wr_sel ? 2'b10 : 2'b01;
      end else begin
        o_wr_rdy <= 2'b00;
      end
      o_rd_rdy   <= (buf_state[rd_sel] == BUF_FULL) && !i_rd_act;
      o_rd_valid <= 1'b0;

      // Write side only touches a buffer that is EMPTY or WRITING, the read
      // side only one that is FULL or READING, so they never collide.
      case (buf_state[wr_sel])
        BUF_EMPTY: begin
          if (i_wr_act[wr_sel] && o_wr_rdy[wr_sel]) begin
            buf_state[wr_sel] <= BUF_WRITING;
            wr_cnt            <= '0;
          end
        end
        BUF_WRITING: begin
          if (!i_wr_act[wr_sel]) begin
            if (wr_cnt != '0) begin
              buf_state[wr_sel] <= BUF_FULL;
              buf_size[wr_sel]  <= wr_cnt;
              wr_sel            <= ~wr_sel;
            end else begin
              buf_state[wr_sel] <= BUF_EMPTY;
            end
          end else if (wr_en) begin
            wr_cnt <= wr_cnt + CNT_ONE;
          end
        end
        default: ;
      endcase

      case (buf_state[rd_sel])
        BUF_FULL: begin
          if (i_rd_act && o_rd_rdy) begin
            buf_state[rd_sel] <= BUF_READING;
            rd_addr           <= '0;
          end
        end
        BUF_READING: begin
          if (!i_rd_act) begin
            buf_state[rd_sel] <= BUF_EMPTY;
            rd_sel            <= ~rd_sel;
          end else if (rd_en) begin
            o_rd_data  <= mem[{rd_sel, rd_addr[ADDR_WIDTH-1:0]}];
            o_rd_valid <= 1'b1;
            rd_addr    <= rd_addr + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ppfifo_sc.sv
// ============================================================================
// Module      : tb_ppfifo_sc
// Description : Directed self-checking bench for the ping-pong FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppfifo_sc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_rdy;
  logic [1:0]  wr_act;
  logic [15:0] wr_size;
  logic        wr_stb;
  logic [7:0]  wr_data;
  logic        rd_rdy;
  logic        rd_act;
  logic [15:0] rd_size;
  logic        rd_stb;
  logic [7:0]  rd_data;
  logic        rd_valid;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];

  ppfifo_sc #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .o_wr_rdy   (wr_rdy),
    .i_wr_act   (wr_act),
    .o_wr_size  (wr_size),
    .i_wr_stb   (wr_stb),
    .i_wr_data  (wr_data),
    .o_rd_rdy   (rd_rdy),
    .i_rd_act   (rd_act),
    .o_rd_size  (rd_size),
    .i_rd_stb   (rd_stb),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Claim buffer b, write n words base, base+1, ..., then release.
  task automatic write_block(input int b, input int n, input logic [7:0] base);
    wr_act = (b == 1) ? 2'b10 : 2'b01;
    tick();
    for (int i = 0; i < n; i++) begin
      wr_stb  = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_stb = 1'b0;
    wr_act = 2'b00;
    tick();
  endtask

  // Claim the read block, issue nstb back-to-back strobes, collect valid words into rx_q.
  task automatic read_block(input int nstb);
    rx_q.delete();
    rd_act = 1'b1;
    tick();
    for (int i = 0; i < nstb; i++) begin
      rd_stb = 1'b1;
      tick();
      if (rd_valid) rx_q.push_back(rd_data);
    end
    rd_stb = 1'b0;
    tick();
    if (rd_valid) rx_q.push_back(rd_data);
    rd_act = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_act = 2'b00; wr_stb = 1'b0; wr_data = 8'h00;
    rd_act = 1'b0; rd_stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wr_rdy !== 2'b00 || rd_rdy !== 1'b0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d wr_rdy=%b rd_rdy=%b rd_valid=%b expected 00 0 0", i, wr_rdy, rd_rdy, rd_valid);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (wr_rdy !== 2'b01) begin
      errors++; $display("FAIL reset_release wr_rdy got %b expected 01", wr_rdy);
    end
    checks++;
    if (wr_size !== 16'd16) begin
      errors++; $display("FAIL wr_size got %0d expected 16", wr_size);
    end
    checks++;
    if (rd_size !== 16'd0) begin
      errors++; $display("FAIL reset_rd_size got %0d expected 0", rd_size);
    end
  endtask

  task automatic test_full_block();
    write_block(0, 16, 8'h00);
    tick();
    checks++;
    if (rd_rdy !== 1'b1 || rd_size !== 16'd16 || wr_rdy !== 2'b10) begin
      errors++;
      $display("FAIL full_commit rd_rdy=%b rd_size=%0d wr_rdy=%b expected 1 16 10", rd_rdy, rd_size, wr_rdy);
    end
    read_block(16);
    checks++;
    if (rx_q.size() != 16) begin
      errors++; $display("FAIL full_count got %0d expected 16", rx_q.size());
    end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i)) begin
        errors++; $display("FAIL full_data[%0d] got %h expected %h", i, rx_q[i], 8'(i));
      end
    end
    // Use buffer1 so the write pointer wraps back to buffer0.
    write_block(1, 1, 8'h55);
    tick();
    checks++;
    if (wr_rdy !== 2'b01 || rd_rdy !== 1'b1) begin
      errors++; $display("FAIL wrap_wr_rdy wr_rdy=%b rd_rdy=%b expected 01 1", wr_rdy, rd_rdy);
    end
    read_block(1);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++; $display("FAIL buf1_data count=%0d first=%h expected 1 55", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_overflow();
    write_block(0, 20, 8'h00);
    tick();
    checks++;
    if (rd_size !== 16'd16 || rd_rdy !== 1'b1) begin
      errors++; $display("FAIL ovf_size rd_size=%0d rd_rdy=%b expected 16 1", rd_size, rd_rdy);
    end
    read_block(17);
    checks++;
    if (rx_q.size() != 16) begin
      errors++; $display("FAIL ovf_count got %0d expected 16", rx_q.size());
    end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i)) begin
        errors++; $display("FAIL ovf_data[%0d] got %h expected %h", i, rx_q[i], 8'(i));
      end
    end
  endtask

  task automatic test_partial_empty();
    write_block(1, 5, 8'hA0);
    tick();
    checks++;
    if (rd_size !== 16'd5 || rd_rdy !== 1'b1) begin
      errors++; $display("FAIL part_size rd_size=%0d rd_rdy=%b expected 5 1", rd_size, rd_rdy);
    end
    read_block(5);
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL part_count got %0d expected 5", rx_q.size());
    end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'hA0 + 8'(i)) begin
        errors++; $display("FAIL part_data[%0d] got %h expected %h", i, rx_q[i], 8'hA0 + 8'(i));
      end
    end
    checks++;
    if (wr_rdy !== 2'b01) begin
      errors++; $display("FAIL empty_pre wr_rdy got %b expected 01", wr_rdy);
    end
    wr_act = 2'b01;
    tick();
    wr_act = 2'b00;
    tick();
    tick();
    checks++;
    if (wr_rdy !== 2'b01 || rd_rdy !== 1'b0 || rd_size !== 16'd0) begin
      errors++;
      $display("FAIL empty_block wr_rdy=%b rd_rdy=%b rd_size=%0d expected 01 0 0", wr_rdy, rd_rdy, rd_size);
    end
    tick();
    checks++;
    if (rd_rdy !== 1'b0) begin
      errors++; $display("FAIL empty_block_late rd_rdy got %b expected 0", rd_rdy);
    end
  endtask

  task automatic test_ping_pong();
    write_block(0, 4, 8'h10);
    tick();
    checks++;
    if (wr_rdy !== 2'b10 || rd_rdy !== 1'b1) begin
      errors++; $display("FAIL pp_first wr_rdy=%b rd_rdy=%b expected 10 1", wr_rdy, rd_rdy);
    end
    rd_act = 1'b1;
    tick();
    // Fill buffer1 while reading the first three words of buffer0.
    wr_act = 2'b10;
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_stb  = 1'b1;
      wr_data = 8'h20 + 8'(i);
      rd_stb  = (i < 3);
      tick();
      checks++;
      if (i < 3) begin
        if (rd_valid !== 1'b1 || rd_data !== 8'h10 + 8'(i)) begin
          errors++;
          $display("FAIL pp_read[%0d] valid=%b data=%h expected 1 %h", i, rd_valid, rd_data, 8'h10 + 8'(i));
        end
      end else if (rd_valid !== 1'b0) begin
        errors++; $display("FAIL pp_idle valid got %b expected 0", rd_valid);
      end
    end
    wr_stb = 1'b0;
    rd_stb = 1'b0;
    wr_act = 2'b00;
    tick();
    tick();
    checks++;
    if (wr_rdy !== 2'b00) begin
      errors++; $display("FAIL pp_both_busy wr_rdy got %b expected 00", wr_rdy);
    end
    rd_act = 1'b0;
    tick();
    tick();
    checks++;
    if (wr_rdy !== 2'b01 || rd_rdy !== 1'b1 || rd_size !== 16'd4) begin
      errors++;
      $display("FAIL pp_second wr_rdy=%b rd_rdy=%b rd_size=%0d expected 01 1 4", wr_rdy, rd_rdy, rd_size);
    end
    read_block(4);
    checks++;
    if (rx_q.size() != 4) begin
      errors++; $display("FAIL pp2_count got %0d expected 4", rx_q.size());
    end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'h20 + 8'(i)) begin
        errors++; $display("FAIL pp2_data[%0d] got %h expected %h", i, rx_q[i], 8'h20 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    write_block(0, 3, 8'h30);
    tick();
    write_block(1, 3, 8'h40);
    tick();
    rd_act = 1'b1;
    tick();
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h30) begin
      errors++; $display("FAIL mid_read valid=%b data=%h expected 1 30", rd_valid, rd_data);
    end
    rst    = 1'b0;
    rd_act = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (rd_rdy !== 1'b0 || rd_size !== 16'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset rd_rdy=%b rd_size=%0d rd_valid=%b expected 0 0 0", rd_rdy, rd_size, rd_valid);
    end
    tick();
    checks++;
    if (wr_rdy !== 2'b01 || rd_rdy !== 1'b0) begin
      errors++; $display("FAIL post_reset wr_rdy=%b rd_rdy=%b expected 01 0", wr_rdy, rd_rdy);
    end
    write_block(0, 2, 8'h77);
    tick();
    checks++;
    if (rd_rdy !== 1'b1 || rd_size !== 16'd2) begin
      errors++; $display("FAIL post_reset_blk rd_rdy=%b rd_size=%0d expected 1 2", rd_rdy, rd_size);
    end
    read_block(2);
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL post_reset_count got %0d expected 2", rx_q.size());
    end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'h77 + 8'(i)) begin
        errors++; $display("FAIL post_reset_data[%0d] got %h expected %h", i, rx_q[i], 8'h77 + 8'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_overflow();
    test_partial_empty();
    test_ping_pong();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
